// File: rtl/if_id_stage.sv
// Fetch stage: owns the PC, drives instruction-memory address, and holds the IF/ID pipeline register.
// Latency: a word fetched at PC A appears on id_inst/id_pc one clock later; imem_addr is combinational from the PC.
// Backpressure: stall holds the PC and IF/ID; redirect (pc_src) overrides stall on the PC; flush overrides stall on IF/ID.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic [6:0]  id_opcode,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [24:0] id_imm_data,
  output logic        target_misaligned
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;

  // Sequential fetch address; wraps naturally at 2^32.
  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // Next PC: redirect beats stall; the redirect target is forced word-aligned.
  always_comb begin
    pc_next = pc_plus4;
    if (pc_src) begin
      pc_next = {pc_target[31:2], 2'b00};
    end else if (stall) begin
      pc_next = pc;
    end
  end

  // PC register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // IF/ID register: flush squashes the instruction but keeps the old PC tags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      id_inst     <= NOP_INST;
      id_pc       <= 32'd0;
      id_pc_plus4 <= 32'd0;
      id_valid    <= 1'b0;
    end else if (flush) begin
      id_inst     <= NOP_INST;
      id_valid    <= 1'b0;
    end else if (!stall) begin
      id_inst     <= imem_rdata;
      id_pc       <= pc;
      id_pc_plus4 <= pc_plus4;
      id_valid    <= 1'b1;
    end
  end

  // One-cycle flag when a redirect target had its low two bits set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      target_misaligned <= 1'b0;
    end else begin
      target_misaligned <= pc_src && (pc_target[1:0] != 2'b00);
    end
  end

  // Decode field slices taken straight from the latched instruction.
  always_comb begin
    id_opcode   = id_inst[6:0];
    id_rd       = id_inst[11:7];
    id_rs1      = id_inst[19:15];
    id_rs2      = id_inst[24:20];
    id_imm_data = id_inst[31:7];
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: stimulus pushes predicted post-edge state, a monitor pops and compares after each edge.
// Latency: expected entry for the edge following each stimulus cycle.
// Backpressure: stall/flush/redirect driven directly (directed plan, then random).
module tb_if_id_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] MEM_KEY  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        pc_src;
  logic [31:0] pc_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rd;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [24:0] id_imm_data;
  logic        target_misaligned;

  logic        ov_en;
  logic [31:0] ov_word;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    logic        valid;
    logic        mis;
    logic        sw_fields;
  } exp_t;

  exp_t model;
  exp_t q[$];

  always #5 clk = ~clk;

  // Instruction memory: address-scrambled words, with an optional override word.
  assign imem_rdata = ov_en ? ov_word : (imem_addr ^ MEM_KEY);

  if_id_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pc_src(pc_src),
    .pc_target(pc_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_inst(id_inst), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_imm_data(id_imm_data), .target_misaligned(target_misaligned)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: what the stage must hold after one edge, from the rules in plain arithmetic.
  function automatic exp_t predict(exp_t cur, logic r, logic st, logic fl, logic ps,
                                   logic [31:0] tgt, logic [31:0] fetched);
    exp_t n;
    n = cur;
    n.sw_fields = 1'b0;
    if (r == 1'b0) begin
      n.pc = RESET_PC; n.inst = NOP_INST; n.ipc = 0; n.ipc4 = 0; n.valid = 0; n.mis = 0;
      return n;
    end
    if (ps)       n.pc = tgt - (tgt % 4);
    else if (!st) n.pc = cur.pc + 4;
    if (fl) begin
      n.inst = NOP_INST; n.valid = 0;
    end else if (!st) begin
      n.inst = fetched; n.ipc = cur.pc; n.ipc4 = cur.pc + 4; n.valid = 1;
    end
    n.mis = ps && (tgt % 4 != 0);
    return n;
  endfunction

  // One stimulus cycle: drive at negedge, push the prediction for the coming edge.
  task automatic cyc(input logic r, input logic st, input logic fl, input logic ps,
                     input logic [31:0] tgt, input logic oe, input logic [31:0] ow,
                     input logic swf = 1'b0);
    logic [31:0] fetched;
    @(negedge clk);
    rst = r; stall = st; flush = fl; pc_src = ps; pc_target = tgt; ov_en = oe; ov_word = ow;
    fetched = oe ? ow : (model.pc ^ MEM_KEY);
    model = predict(model, r, st, fl, ps, tgt, fetched);
    model.sw_fields = swf;
    q.push_back(model);
  endtask

  // Monitor: after every rising edge compare DUT state against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("imem_addr", imem_addr, e.pc);
        chk("id_inst", id_inst, e.inst);
        chk("id_pc", id_pc, e.ipc);
        chk("id_pc_plus4", id_pc_plus4, e.ipc4);
        chk("id_valid", {31'd0, id_valid}, {31'd0, e.valid});
        chk("target_misaligned", {31'd0, target_misaligned}, {31'd0, e.mis});
        chk("id_opcode", {25'd0, id_opcode}, {25'd0, e.inst[6:0]});
        chk("id_rd", {27'd0, id_rd}, {27'd0, e.inst[11:7]});
        chk("id_rs1", {27'd0, id_rs1}, {27'd0, e.inst[19:15]});
        chk("id_rs2", {27'd0, id_rs2}, {27'd0, e.inst[24:20]});
        chk("id_imm_data", {7'd0, id_imm_data}, {7'd0, e.inst[31:7]});
        if (e.sw_fields) begin
          chk("sw_opcode", {25'd0, id_opcode}, 32'h23);
          chk("sw_rs1", {27'd0, id_rs1}, 32'd1);
          chk("sw_rs2", {27'd0, id_rs2}, 32'd2);
          chk("sw_rd", {27'd0, id_rd}, 32'h1C);
          chk("sw_imm", {7'd0, id_imm_data}, 32'h01FC_415C);
        end
      end
    end
  end

  initial begin
    int budget;
    logic [31:0] t;
    model = '{pc: 0, inst: 0, ipc: 0, ipc4: 0, valid: 0, mis: 0, sw_fields: 0};
    rst = 0; stall = 0; flush = 0; pc_src = 0; pc_target = 0; ov_en = 0; ov_word = 0;

    // Reset then run sequentially.
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Stall three cycles at pc=8, then resume.
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Field slicing on a store word.
    cyc(1, 0, 0, 0, 0, 1, 32'hFE20_AE23, 1'b1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Redirect + flush while stalled.
    cyc(1, 1, 1, 1, 32'h0000_0100, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Misaligned target, then quiet cycles.
    cyc(1, 0, 1, 1, 32'h0000_0206, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Redirect without flush lets the current fetch through.
    cyc(1, 0, 0, 1, 32'h0000_0400, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // PC wrap.
    cyc(1, 0, 1, 1, 32'hFFFF_FFFC, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Misaligned redirect pending, then reset during stall+flush+redirect.
    cyc(1, 0, 0, 1, 32'h0000_0033, 0, 0);
    cyc(0, 1, 1, 1, 32'h0000_0077, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r, st, fl, ps, oe;
      r  = ($urandom_range(0, 99) != 0);
      st = ($urandom_range(0, 99) < 30);
      ps = ($urandom_range(0, 99) < 15);
      fl = ps ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 99) < 5);
      oe = ($urandom_range(0, 3) == 0);
      t  = $urandom();
      if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
      cyc(r, st, fl, ps, t, oe, $urandom());
    end

    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d pending required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
Fetch stage and IF/ID pipeline register of the 5-stage RISC-V core. It owns the PC and drives the instruction-memory address. It latches the fetched word with its PC and PC+4 into the IF/ID register, and exposes the decode fields. Those fields include the 25-bit immediate slice consumed directly by the decode-stage immediate extender. Stall comes from the hazard unit; flush and redirect come from EX-stage branch/jump resolution.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0013, bubble word (addi x0,x0,0) loaded into IF/ID on reset and flush

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low (sampled on rising clk; 0 = reset)
stall  input  1  hazard unit: hold PC and IF/ID
flush  input  1  squash IF/ID contents (branch/jump taken in EX)
pc_src  input  1  redirect PC to pc_target
pc_target  input  32  branch/jump target from EX
imem_addr  output  32  instruction memory address (= PC, combinational)
imem_rdata  input  32  instruction word, combinational read of imem_addr
id_inst  output  32  IF/ID instruction
id_pc  output  32  PC of id_inst
id_pc_plus4  output  32  id_pc + 4
id_valid  output  1  1 = id_inst is a real fetched instruction, 0 = bubble
id_opcode  output  7  id_inst[6:0]
id_rd  output  5  id_inst[11:7]
id_rs1  output  5  id_inst[19:15]
id_rs2  output  5  id_inst[24:20]
id_imm_data  output  25  id_inst[31:7], feeds immediate extender data input
target_misaligned  output  1  one-cycle pulse: redirect target had nonzero bits [1:0]

Behaviour:
- Reset (rst==0 at posedge) has top priority over every other input, including mid-stall or mid-flush. Reset values:
  - pc = RESET_PC
  - id_inst = NOP_INST
  - id_pc = 0, id_pc_plus4 = 0, id_valid = 0
  - target_misaligned = 0
- imem_addr = pc, purely combinational. Field outputs are pure combinational slices of id_inst.
- At each posedge with rst==1, the PC register updates as follows:
  - pc_src==1: pc <= {pc_target[31:2],2'b00}. The redirect overrides stall.
  - else stall==1: pc holds.
  - else: pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- At each posedge with rst==1, the IF/ID register updates as follows:
  - flush==1: id_inst <= NOP_INST, id_valid <= 0. id_pc and id_pc_plus4 hold their previous values. Flush overrides stall.
  - else stall==1: all IF/ID fields hold.
  - else: id_inst <= imem_rdata, id_pc <= pc, id_pc_plus4 <= pc + 4 (wrapping), id_valid <= 1.
- pc_src and flush are independent inputs. Normal use asserts both together. pc_src without flush still redirects and lets the current fetch enter IF/ID.
- Latency: a word fetched while pc==A appears on id_inst/id_pc at the next edge, i.e. one cycle.
- target_misaligned:
  - Registered; set to 1 for exactly one cycle after any edge where pc_src==1 and pc_target[1:0]!=0, otherwise 0.
  - The PC is still redirected to the aligned target.
- Stall held for N cycles: pc, imem_addr and all IF/ID outputs stay constant for N cycles. Fetch resumes at the same address.

Test Plan:
1. Reset and run: rst=0 for 2 cycles, RESET_PC=0, then release; imem returns word=addr^32'hA5A5_0000 -> after reset id_inst=32'h0000_0013, id_valid=0; cycle 1 after release id_pc=0, id_inst=32'hA5A5_0000, id_valid=1; cycle 2 id_pc=4, id_pc_plus4=8.
2. Field slicing: fetch 32'hFE20_AE23 (sw x2,-4(x1)) -> id_opcode=7'h23, id_rs1=1, id_rs2=2, id_rd=5'h1C, id_imm_data=25'h1FC_415C.
3. Stall: assert stall 3 cycles while pc=8 -> imem_addr stays 8 and id_pc stays 4 for 3 cycles; after release id_pc=8.
4. Redirect and flush during stall:
   - Setup: stall=1, flush=1, pc_src=1, pc_target=32'h0000_0100.
   - Required: next cycle pc=0x100, id_inst=NOP_INST, id_valid=0.
   - Then: following cycle id_pc=0x100.
5. Misaligned target: pc_src=1, pc_target=32'h0000_0206 -> pc=0x204; target_misaligned=1 for one cycle, then 0.
6. Wrap and mid-operation reset:
   - Wrap: force a redirect to 32'hFFFF_FFFC -> next pc=0, and id_pc_plus4=0 for that instruction.
   - Reset: assert rst=0 during active stall and flush -> pc=RESET_PC, id_valid=0, target_misaligned=0 at the next edge.
